spi_tx_feeder: RTL and testbench
================================

# spi_tx_feeder

Byte queue and transfer sequencer that sits directly upstream of `spi_master`. Producers (button/counter logic in `top`, later a UART bridge) push bytes at any rate into a small FIFO. The block drains the FIFO one byte at a time by driving `spi_master`'s `tx_data`/`start_tx` and waiting for `tx_done`. It enforces a programmable idle gap between frames and a timeout if the master never completes.

## Interface
Parameters:
- `DEPTH`, 8 — FIFO entries; power of two, ≥2.
- `GAP_CLKS`, 16 — idle clocks between `tx_done` and the next `spi_start_tx`; 0 allowed.
- `TIMEOUT_CLKS`, 4096 — max clocks spent waiting for the master per byte.

Ports (AW = log2(DEPTH)):
- `clk`  in  1  system clock; sole clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  push request.
- `wr_data`  in  8  byte to push.
- `full`  out  1  FIFO holds DEPTH bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `count`  out  AW+1  current occupancy.
- `overflow`  out  1  sticky: a push was attempted while full.
- `timeout`  out  1  sticky: a byte was abandoned after TIMEOUT_CLKS.
- `clr_flags`  in  1  synchronous clear of `overflow` and `timeout`.
- `busy`  out  1  sequencer not in IDLE.
- `spi_tx_data`  out  8  to `spi_master.tx_data`; held stable from START until the sequencer leaves WAIT_DONE.
- `spi_start_tx`  out  1  to `spi_master.start_tx`; one-cycle pulse.
- `spi_tx_done`  in  1  from `spi_master.tx_done`; sampled as a level.

## Operation
- Push: `wr_en && !full` writes `wr_data` at `wr_ptr` and increments `wr_ptr` mod DEPTH.
- `wr_en && full` drops the byte and sets `overflow`. This applies even if a pop occurs in the same cycle, because `full` is a registered value.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- Pointers are AW bits and wrap naturally. `count` is tracked explicitly; `full`/`empty` are registered and derived from the next count.
- FSM states: IDLE, START, WAIT_ACK, WAIT_DONE, GAP.
  - IDLE: if `!empty`, load the head byte into `spi_tx_data`, pop it (`rd_ptr`+1, count−1), and go to START.
  - START: `spi_start_tx`=1 for this cycle only; clear the timeout counter; go to WAIT_ACK.
  - WAIT_ACK: wait for `spi_tx_done`=0, meaning the master has accepted the byte and dropped its previous done. Then go to WAIT_DONE.
  - WAIT_DONE: wait for `spi_tx_done`=1. Load the gap counter with GAP_CLKS and go to GAP, or go straight to IDLE if GAP_CLKS=0.
  - GAP: decrement the counter; go to IDLE when it reaches 0.
- Timeout: a single counter runs through WAIT_ACK and WAIT_DONE. When it reaches TIMEOUT_CLKS−1, set `timeout`, discard the byte (no retry), and go to GAP.
- `clr_flags` in the same cycle as a new overflow or timeout event: the set wins.
- `busy` = (state != IDLE).

## Timing
- Reset (async assert, sync release) forces:
  - `full`=0, `empty`=1, `count`=0, pointers 0.
  - `overflow`=0, `timeout`=0, `busy`=0.
  - `spi_start_tx`=0, `spi_tx_data`=8'h00, state IDLE.
  - FIFO contents are not reset.
- Reset mid-transfer abandons the queue and the in-flight byte. `spi_master` is reset from the same source in `top`.
- Latency: a write accepted at edge N into an empty queue with the FSM in IDLE gives `empty`=0 after N, IDLE→START at N+1, and `spi_start_tx` high during cycle N+1→N+2.
- Back-to-back throughput: one byte per (master frame + GAP_CLKS + 3) clocks.
- All outputs are registered; there is no combinational path from `spi_tx_done` or `wr_en` to any output.

## Structure
- Package `spi_pkg`:
  - FSM state encoding (`FEED_IDLE`…`FEED_GAP`).
  - `SPI_BYTE_W`=8.
  - Default GAP/TIMEOUT constants, shared with `spi_master`.
- Sub-module `sync_fifo` (DEPTH, width 8; push/pop/full/empty/count) is instantiated once. The sequencer FSM lives in `spi_tx_feeder`.

## Test plan
- Reset with `wr_en` high: outputs hold their reset values; no write occurs until reset deasserts.
- Push 8'hA5 into an idle block; model master raises `tx_done` 20 clocks after start → one `spi_start_tx` pulse 2 cycles after the write, `spi_tx_data`=8'hA5, `busy` low exactly GAP_CLKS+1 cycles after `tx_done`.
- Push 8'h01..8'h09 with DEPTH=8 and a stalled master → `full` after 8 pushes, 9th dropped, `overflow`=1; bytes later emerge 01..08 in order; `clr_flags` clears `overflow`.
- Master never raises `tx_done` → `timeout`=1 after TIMEOUT_CLKS, the byte is skipped, and the next queued byte starts after the gap.
- Simultaneous push and pop at count=3 → count stays 3; pointer wrap exercised over 20 bytes with data integrity.
- Assert reset in WAIT_DONE with 4 bytes queued → `empty`=1, `count`=0, `busy`=0; no `spi_start_tx` after release until a new push.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI constants, feeder FSM encoding and a counter-width helper.
// Pure declarations: no latency, no flow control.
package spi_pkg;

   localparam int SPI_BYTE_W           = 8;
   localparam int SPI_GAP_CLKS_DEF     = 16;
   localparam int SPI_TIMEOUT_CLKS_DEF = 4096;

   typedef logic [SPI_BYTE_W-1:0] spi_byte_t;

   typedef enum logic [2:0] {
      FEED_IDLE,
      FEED_START,
      FEED_WAIT_ACK,
      FEED_WAIT_DONE,
      FEED_GAP
   } feed_state_e;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/spi_tx_feeder_if.sv
// Producer-side queue port plus the spi_master control lines of the feeder.
// slave = the feeder itself, master = whoever pushes bytes and models the SPI master.
interface spi_tx_feeder_if #(
   parameter int DEPTH = 8
);
   import spi_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic      wr_en;
   spi_byte_t wr_data;
   logic      full;
   logic      empty;
   logic [AW:0] count;
   logic      overflow;
   logic      timeout;
   logic      clr_flags;
   logic      busy;
   spi_byte_t spi_tx_data;
   logic      spi_start_tx;
   logic      spi_tx_done;

   modport slave (
      input  wr_en, wr_data, clr_flags, spi_tx_done,
      output full, empty, count, overflow, timeout, busy, spi_tx_data, spi_start_tx
   );

   modport master (
      output wr_en, wr_data, clr_flags, spi_tx_done,
      input  full, empty, count, overflow, timeout, busy, spi_tx_data, spi_start_tx
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with explicit occupancy count; head word is read combinationally.
// Registered full/empty/count one clock after push/pop; push while full and pop while empty are ignored.
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_vld,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop_vld,
   output logic [WIDTH-1:0]         pop_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             push_acc, pop_acc;

   assign push_acc = push_vld && !full_q;
   assign pop_acc  = pop_vld && !empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_acc && !pop_acc)
         count_d = count_q + (AW+1)'(1);
      else if (!push_acc && pop_acc)
         count_d = count_q - (AW+1)'(1);
      full_d  = (count_d == (AW+1)'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push_acc) mem_q[wr_ptr_q] <= push_dat;
   end

   assign pop_dat = mem_q[rd_ptr_q];
   assign full    = full_q;
   assign empty   = empty_q;
   assign count   = count_q;

endmodule

// File: rtl/spi_tx_feeder.sv
// Byte queue and one-frame-at-a-time sequencer in front of spi_master, with inter-frame gap and timeout.
// Write to start_tx pulse is 2 clocks; producers are never stalled (full/overflow only), the master paces via tx_done.
module spi_tx_feeder
   import spi_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int GAP_CLKS     = SPI_GAP_CLKS_DEF,
   parameter int TIMEOUT_CLKS = SPI_TIMEOUT_CLKS_DEF
) (
   input  logic            clk,
   input  logic            reset,
   spi_tx_feeder_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int GW = cnt_w(GAP_CLKS);
   localparam int TW = cnt_w(TIMEOUT_CLKS);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CLKS);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLKS - 1);

   feed_state_e   state_q, state_d;
   spi_byte_t     tx_data_q, tx_data_d;
   logic          start_tx_q, start_tx_d;
   logic          busy_q, busy_d;
   logic          overflow_q, overflow_d;
   logic          timeout_q, timeout_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;

   logic          pop_vld;
   spi_byte_t     head_dat;
   logic          fifo_full, fifo_empty;
   logic [AW:0]   fifo_count;
   logic          frame_end, timeout_evt;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (SPI_BYTE_W)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (bus.wr_en),
      .push_dat (bus.wr_data),
      .pop_vld  (pop_vld),
      .pop_dat  (head_dat),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   always_comb begin
      state_d     = state_q;
      tx_data_d   = tx_data_q;
      start_tx_d  = 1'b0;
      gap_cnt_d   = gap_cnt_q;
      to_cnt_d    = to_cnt_q;
      pop_vld     = 1'b0;
      frame_end   = 1'b0;
      timeout_evt = 1'b0;

      case (state_q)
         FEED_IDLE: begin
            if (!fifo_empty) begin
               pop_vld    = 1'b1;
               tx_data_d  = head_dat;
               start_tx_d = 1'b1;
               state_d    = FEED_START;
            end
         end
         FEED_START: begin
            to_cnt_d = '0;
            state_d  = FEED_WAIT_ACK;
         end
         // Progress wins over a timeout landing in the same cycle.
         FEED_WAIT_ACK: begin
            if (!bus.spi_tx_done) begin
               to_cnt_d = to_cnt_q + TW'(1);
               state_d  = FEED_WAIT_DONE;
            end else if (to_cnt_q >= TO_LAST) begin
               timeout_evt = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end
         FEED_WAIT_DONE: begin
            if (bus.spi_tx_done)
               frame_end = 1'b1;
            else if (to_cnt_q >= TO_LAST)
               timeout_evt = 1'b1;
            else
               to_cnt_d = to_cnt_q + TW'(1);
         end
         FEED_GAP: begin
            gap_cnt_d = gap_cnt_q - GW'(1);
            if (gap_cnt_q <= GW'(1)) state_d = FEED_IDLE;
         end
         default: state_d = FEED_IDLE;
      endcase

      // A completed or abandoned byte both lead into the idle gap.
      if (frame_end || timeout_evt) begin
         if (GAP_CLKS == 0) begin
            state_d = FEED_IDLE;
         end else begin
            state_d   = FEED_GAP;
            gap_cnt_d = GAP_LOAD;
         end
      end

      busy_d     = (state_d != FEED_IDLE);
      overflow_d = (bus.wr_en && fifo_full) ? 1'b1 : (bus.clr_flags ? 1'b0 : overflow_q);
      timeout_d  = timeout_evt ? 1'b1 : (bus.clr_flags ? 1'b0 : timeout_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= FEED_IDLE;
         tx_data_q  <= '0;
         start_tx_q <= 1'b0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
         gap_cnt_q  <= '0;
         to_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         start_tx_q <= start_tx_d;
         busy_q     <= busy_d;
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
         gap_cnt_q  <= gap_cnt_d;
         to_cnt_q   <= to_cnt_d;
      end
   end

   assign bus.full         = fifo_full;
   assign bus.empty        = fifo_empty;
   assign bus.count        = fifo_count;
   assign bus.overflow     = overflow_q;
   assign bus.timeout      = timeout_q;
   assign bus.busy         = busy_q;
   assign bus.spi_tx_data  = tx_data_q;
   assign bus.spi_start_tx = start_tx_q;

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Directed bench for spi_tx_feeder with a behavioural spi_master that answers start_tx after m_lat clocks.
// All bench activity happens just after the falling edge; the master model acts exactly on it.
module tb_spi_tx_feeder;

   localparam int DEPTH = 8;
   localparam int GAP   = 4;
   localparam int TMO   = 64;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   spi_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

   spi_tx_feeder #(
      .DEPTH        (DEPTH),
      .GAP_CLKS     (GAP),
      .TIMEOUT_CLKS (TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   bit         m_hang    = 1'b0;
   int         m_lat     = 20;
   bit         m_pending = 1'b0;
   int         m_cnt     = 0;
   int         starts    = 0;
   logic [7:0] cap_q [$];

   // Master model: drops done on start, raises it m_lat clocks later unless hung.
   initial begin
      bus.spi_tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            m_pending       = 1'b0;
            m_cnt           = 0;
            bus.spi_tx_done = 1'b0;
         end else if (bus.spi_start_tx === 1'b1) begin
            cap_q.push_back(bus.spi_tx_data);
            starts++;
            m_pending       = 1'b1;
            m_cnt           = m_lat;
            bus.spi_tx_done = 1'b0;
         end else if (m_pending && !m_hang) begin
            if (m_cnt > 1) begin
               m_cnt--;
            end else begin
               bus.spi_tx_done = 1'b1;
               m_pending       = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (!bus.busy && bus.empty) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [17:0] obs;
      logic [17:0] exp_v;
      exp_v = {1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      reset         = 1'b0;
      bus.wr_en     = 1'b1;
      bus.wr_data   = 8'h5A;
      bus.clr_flags = 1'b0;
      repeat (4) tick();
      obs = {bus.full, bus.empty, bus.count, bus.overflow, bus.timeout,
             bus.busy, bus.spi_start_tx, bus.spi_tx_data};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset_held: got %h expected %h", obs, exp_v);
      end
      bus.wr_en = 1'b0;
      reset     = 1'b1;
      repeat (3) tick();
      obs = {bus.full, bus.empty, bus.count, bus.overflow, bus.timeout,
             bus.busy, bus.spi_start_tx, bus.spi_tx_data};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset_release_no_write: got %h expected %h", obs, exp_v);
      end
   endtask

   task automatic test_single();
      int n;
      int s0;
      bit seen;
      m_hang = 1'b0;
      m_lat  = 20;
      s0     = starts;
      push(8'hA5);
      checks++;
      if (bus.empty !== 1'b0 || bus.spi_start_tx !== 1'b0) begin
         errors++;
         $display("FAIL single_after_write: empty=%b start=%b expected empty=0 start=0", bus.empty, bus.spi_start_tx);
      end
      tick();
      checks++;
      if (bus.spi_start_tx !== 1'b1 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL single_start_pulse: start=%b busy=%b expected 1 1", bus.spi_start_tx, bus.busy);
      end
      checks++;
      if (bus.spi_tx_data !== 8'hA5) begin
         errors++;
         $display("FAIL single_tx_data: got %h expected a5", bus.spi_tx_data);
      end
      n    = 0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         n++;
         if (!bus.busy) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen || n != 20 + GAP + 1) begin
         errors++;
         $display("FAIL single_busy_release: clocks=%0d expected %0d", n, 20 + GAP + 1);
      end
      checks++;
      if (starts - s0 != 1) begin
         errors++;
         $display("FAIL single_pulse_count: got %0d expected 1", starts - s0);
      end
   endtask

   task automatic test_overflow();
      bit ok;
      cap_q.delete();
      m_hang = 1'b1;
      m_lat  = 20;
      push(8'hEE);
      tick();
      for (int i = 1; i <= 8; i++) push(8'(i));
      checks++;
      if (bus.full !== 1'b1 || bus.count !== 4'd8 || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_full: full=%b count=%0d ovf=%b expected 1 8 0", bus.full, bus.count, bus.overflow);
      end
      push(8'h09);
      checks++;
      if (bus.overflow !== 1'b1 || bus.count !== 4'd8) begin
         errors++;
         $display("FAIL ovf_drop: ovf=%b count=%0d expected 1 8", bus.overflow, bus.count);
      end
      m_hang = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (cap_q.size() >= 9) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok || cap_q[0] !== 8'hEE) begin
         errors++;
         $display("FAIL ovf_drain: frames=%0d first=%h expected 9 frames first ee", cap_q.size(), cap_q[0]);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (cap_q[i+1] !== 8'(i + 1)) begin
            errors++;
            $display("FAIL ovf_order[%0d]: got %h expected %h", i, cap_q[i+1], 8'(i + 1));
         end
      end
      wait_idle(300, ok);
      checks++;
      if (!ok || cap_q.size() != 9 || bus.timeout !== 1'b0) begin
         errors++;
         $display("FAIL ovf_idle: idle=%0d frames=%0d timeout=%b expected 1 9 0", ok, cap_q.size(), bus.timeout);
      end
      bus.clr_flags = 1'b1;
      tick();
      bus.clr_flags = 1'b0;
      checks++;
      if (bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: got %b expected 0", bus.overflow);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int n;
      int m;
      cap_q.delete();
      m_hang = 1'b1;
      push(8'hB1);
      tick();
      checks++;
      if (bus.spi_start_tx !== 1'b1 || bus.spi_tx_data !== 8'hB1) begin
         errors++;
         $display("FAIL tmo_first_start: start=%b data=%h expected 1 b1", bus.spi_start_tx, bus.spi_tx_data);
      end
      push(8'hB2);
      n  = 1;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         n++;
         if (bus.timeout) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok || n != TMO + 1) begin
         errors++;
         $display("FAIL tmo_latency: clocks=%0d expected %0d", n, TMO + 1);
      end
      m_hang = 1'b0;
      m  = 0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         m++;
         if (bus.spi_start_tx) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok || m != GAP + 1 || bus.spi_tx_data !== 8'hB2) begin
         errors++;
         $display("FAIL tmo_next_byte: clocks=%0d data=%h expected %0d b2", m, bus.spi_tx_data, GAP + 1);
      end
      wait_idle(300, ok);
      checks++;
      if (!ok || cap_q.size() != 2 || bus.timeout !== 1'b1) begin
         errors++;
         $display("FAIL tmo_no_retry: idle=%0d frames=%0d timeout=%b expected 1 2 1", ok, cap_q.size(), bus.timeout);
      end
      bus.clr_flags = 1'b1;
      tick();
      bus.clr_flags = 1'b0;
      checks++;
      if (bus.timeout !== 1'b0) begin
         errors++;
         $display("FAIL tmo_clear: got %b expected 0", bus.timeout);
      end
   endtask

   task automatic test_push_pop();
      bit ok;
      logic [7:0] exp_b [5];
      exp_b = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
      cap_q.delete();
      m_hang = 1'b1;
      m_lat  = 20;
      push(8'hC0);
      tick();
      push(8'hC1);
      push(8'hC2);
      push(8'hC3);
      m_hang = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (!bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok || bus.count !== 4'd3) begin
         errors++;
         $display("FAIL pp_setup: idle=%0d count=%0d expected 1 3", ok, bus.count);
      end
      push(8'hC4);
      checks++;
      if (bus.count !== 4'd3 || bus.spi_start_tx !== 1'b1 || bus.spi_tx_data !== 8'hC1) begin
         errors++;
         $display("FAIL pp_simultaneous: count=%0d start=%b data=%h expected 3 1 c1", bus.count, bus.spi_start_tx, bus.spi_tx_data);
      end
      wait_idle(600, ok);
      checks++;
      if (!ok || cap_q.size() != 5) begin
         errors++;
         $display("FAIL pp_drain: idle=%0d frames=%0d expected 1 5", ok, cap_q.size());
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (cap_q[i] !== exp_b[i]) begin
            errors++;
            $display("FAIL pp_order[%0d]: got %h expected %h", i, cap_q[i], exp_b[i]);
         end
      end
   endtask

   task automatic test_wrap();
      bit ok;
      logic [7:0] exp_q [$];
      logic [7:0] d;
      cap_q.delete();
      m_lat = 3;
      for (int i = 0; i < 20; i++) begin
         for (int w = 0; w < 100 && bus.full; w++) tick();
         d = 8'(i * 29 + 7);
         exp_q.push_back(d);
         push(d);
      end
      wait_idle(1000, ok);
      checks++;
      if (!ok || cap_q.size() != 20 || bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL wrap_drain: idle=%0d frames=%0d ovf=%b expected 1 20 0", ok, cap_q.size(), bus.overflow);
      end
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (cap_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL wrap_data[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int s0;
      logic [17:0] obs;
      logic [17:0] exp_v;
      exp_v = {1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      m_lat  = 20;
      m_hang = 1'b1;
      push(8'hD0);
      tick();
      for (int i = 1; i <= 4; i++) push(8'hD0 + 8'(i));
      tick();
      checks++;
      if (bus.busy !== 1'b1 || bus.count !== 4'd4) begin
         errors++;
         $display("FAIL mid_setup: busy=%b count=%0d expected 1 4", bus.busy, bus.count);
      end
      reset = 1'b0;
      #1;
      obs = {bus.full, bus.empty, bus.count, bus.overflow, bus.timeout,
             bus.busy, bus.spi_start_tx, bus.spi_tx_data};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL mid_reset_state: got %h expected %h", obs, exp_v);
      end
      tick();
      reset  = 1'b1;
      m_hang = 1'b0;
      s0     = starts;
      repeat (30) tick();
      checks++;
      if (starts != s0 || bus.empty !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_quiet: pulses=%0d empty=%b busy=%b expected 0 1 0", starts - s0, bus.empty, bus.busy);
      end
      push(8'h77);
      tick();
      checks++;
      if (bus.spi_start_tx !== 1'b1 || bus.spi_tx_data !== 8'h77) begin
         errors++;
         $display("FAIL mid_restart: start=%b data=%h expected 1 77", bus.spi_start_tx, bus.spi_tx_data);
      end
      wait_idle(300, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL mid_final_idle: busy=%b empty=%b expected 0 1", bus.busy, bus.empty);
      end
   endtask

   initial begin
      bus.wr_en     = 1'b0;
      bus.wr_data   = 8'h00;
      bus.clr_flags = 1'b0;
      test_reset();
      test_single();
      test_overflow();
      test_timeout();
      test_push_pop();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
